// File: rtl/src_scheduler.sv
// src_scheduler: sequences and time-slices the fibonacci and timer producers onto the single CDC FIFO write port.
// Latency: an accepted word reaches wr_en/wr_data one cycle later when the FIFO is not full; the enables are decoded from registered state.
// Backpressure: buffer_full drops the enables on the next cycle; one in-flight word is parked in a hold register, and a word arriving while it is occupied is dropped (sticky overflow).
//
// Ports:
//   clk, rst                     : clock and async active-high reset
//   start_f, start_t, stop       : single-cycle arm / drain pulses
//   f_valid/f_data, t_valid/t_data : producer word strobes and data
//   buffer_full, buffer_empty    : FIFO write-side status
//   data_2_valid                 : FIFO read side still presenting a word
//   f_en, t_en                   : producer enables
//   wr_en, wr_data, wr_parity    : registered FIFO write port
//   modulo                       : active source (10 fib, 01 timer, 00 idle)
//   word_cnt, overflow           : write counter and sticky lost-word flag
// Build option: define SCHED_PARITY_EN to register wr_parity = ^wr_data; otherwise wr_parity is tied to 0.

module src_scheduler #(
    parameter int DATA_W = 16,
    parameter int SLICE  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_f,
    input  logic              start_t,
    input  logic              stop,
    input  logic              f_valid,
    input  logic              t_valid,
    input  logic [DATA_W-1:0] f_data,
    input  logic [DATA_W-1:0] t_data,
    input  logic              buffer_full,
    input  logic              buffer_empty,
    input  logic              data_2_valid,
    output logic              f_en,
    output logic              t_en,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        modulo,
    output logic [15:0]       word_cnt,
    output logic              overflow,
    output logic              wr_parity
);

    localparam int SW = (SLICE > 1) ? $clog2(SLICE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_STALL,
        S_SWITCH,
        S_DRAIN
    } state_t;

    // Grant encoding: 0 = fibonacci, 1 = timer.
    localparam logic G_F = 1'b0;
    localparam logic G_T = 1'b1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_g;
    logic              r_last;
    logic              r_arm_f;
    logic              r_arm_t;
    logic [SW-1:0]     r_slice_cnt;
    logic              r_hold_vld;
    logic [DATA_W-1:0] r_hold_dat;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    logic [15:0]       r_word_cnt;
    logic              r_overflow;

    logic              w_f_en;
    logic              w_t_en;
    logic [1:0]        w_modulo;
    logic              w_acc;
    logic [DATA_W-1:0] w_word;
    logic              w_other_arm;
    logic              w_slice_end;
    logic              w_pick;
    logic              w_flush;
    logic              w_direct;
    logic              w_write;

    // Only the granted source is ever listened to; the other source's strobe is ignored.
    assign w_word      = r_g ? t_data : f_data;
    assign w_acc       = (r_state != S_IDLE) && (r_g ? t_valid : f_valid);
    assign w_other_arm = r_g ? r_arm_f : r_arm_t;
    assign w_slice_end = (r_slice_cnt == SW'(SLICE - 1));

    // Round-robin pick on leaving IDLE: prefer the source that did not have the last grant.
    assign w_pick = (r_last ? r_arm_f : r_arm_t) ? ~r_last : r_last;

    // A hold flush always wins the write port; a direct write needs the hold register empty,
    // so the two can never collide and an accept during a flush lands in hold.
    assign w_flush  = r_hold_vld && !buffer_full;
    assign w_direct = w_acc && !r_hold_vld && !buffer_full;
    assign w_write  = w_flush || w_direct;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_f_en      = 1'b0;
        w_t_en      = 1'b0;
        w_modulo    = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (r_arm_f || r_arm_t) w_state_nxt = S_GRANT;
            end
            S_GRANT: begin
                w_f_en = (r_g == G_F);
                w_t_en = (r_g == G_T);
                if (stop)                                    w_state_nxt = S_DRAIN;
                else if (buffer_full)                        w_state_nxt = S_STALL;
                else if (w_acc && w_slice_end && w_other_arm) w_state_nxt = S_SWITCH;
            end
            S_STALL: begin
                if (stop)                             w_state_nxt = S_DRAIN;
                else if (!buffer_full && !r_hold_vld) w_state_nxt = S_GRANT;
            end
            S_SWITCH: begin
                // One dead cycle so a word already launched by the old source is still caught.
                if (stop)             w_state_nxt = S_DRAIN;
                else if (buffer_full) w_state_nxt = S_STALL;
                else                  w_state_nxt = S_GRANT;
            end
            S_DRAIN: begin
                if (!r_hold_vld && buffer_empty && !data_2_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (r_state != S_IDLE) w_modulo = r_g ? 2'b01 : 2'b10;
    end

    // Arming, grant and slice bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arm_f     <= 1'b0;
            r_arm_t     <= 1'b0;
            r_g         <= G_F;
            r_last      <= G_T;
            r_slice_cnt <= '0;
        end else begin
            if (r_state == S_DRAIN) begin
                if (w_state_nxt == S_IDLE) begin
                    r_arm_f <= 1'b0;
                    r_arm_t <= 1'b0;
                end
            end else begin
                r_arm_f <= r_arm_f | start_f;
                r_arm_t <= r_arm_t | start_t;
            end

            if (r_state == S_IDLE && (r_arm_f || r_arm_t)) begin
                r_g         <= w_pick;
                r_last      <= w_pick;
                r_slice_cnt <= '0;
            end else if (r_state == S_SWITCH) begin
                r_g         <= ~r_g;
                r_last      <= ~r_g;
                r_slice_cnt <= '0;
            end else if (r_state == S_GRANT && w_acc) begin
                r_slice_cnt <= w_slice_end ? '0 : r_slice_cnt + SW'(1);
            end
        end
    end

    // Write path with one-word hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_vld <= 1'b0;
            r_hold_dat <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_data  <= w_flush ? r_hold_dat : w_word;
                r_word_cnt <= r_word_cnt + 16'd1;
            end

            if (w_acc && !w_direct) begin
                if (r_hold_vld && !w_flush) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_hold_vld <= 1'b1;
                    r_hold_dat <= w_word;
                end
            end else if (w_flush) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

`ifdef SCHED_PARITY_EN
    logic r_wr_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_parity <= 1'b0;
        end else if (w_write) begin
            r_wr_parity <= w_flush ? ^r_hold_dat : ^w_word;
        end
    end

    assign wr_parity = r_wr_parity;
`else
    assign wr_parity = 1'b0;
`endif

    assign f_en     = w_f_en;
    assign t_en     = w_t_en;
    assign modulo   = w_modulo;
    assign wr_en    = r_wr_en;
    assign wr_data  = r_wr_data;
    assign word_cnt = r_word_cnt;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_src_scheduler.sv
// tb_src_scheduler: directed scoreboard bench for src_scheduler (SLICE=2).
// Latency: checks sampled 1 time unit after posedge; writes popped on negedge.
// Backpressure: bench drives buffer_full/buffer_empty/data_2_valid directly.

module tb_src_scheduler;

    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          start_f, start_t, stop;
    logic          f_valid, t_valid;
    logic [DW-1:0] f_data, t_data;
    logic          buffer_full, buffer_empty, data_2_valid;
    logic          f_en, t_en, wr_en, overflow, wr_parity;
    logic [DW-1:0] wr_data;
    logic [1:0]    modulo;
    logic [15:0]   word_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] sb_q[$];

    src_scheduler #(.DATA_W(DW), .SLICE(2)) dut (
        .clk(clk), .rst(rst),
        .start_f(start_f), .start_t(start_t), .stop(stop),
        .f_valid(f_valid), .t_valid(t_valid),
        .f_data(f_data), .t_data(t_data),
        .buffer_full(buffer_full), .buffer_empty(buffer_empty),
        .data_2_valid(data_2_valid),
        .f_en(f_en), .t_en(t_en), .wr_en(wr_en), .wr_data(wr_data),
        .modulo(modulo), .word_cnt(word_cnt), .overflow(overflow),
        .wr_parity(wr_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_par(input logic [DW-1:0] d);
`ifdef SCHED_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    // Scoreboard: every write must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {16'h0, wr_data}, 32'hDEAD_BEEF);
            end else begin
                logic [DW-1:0] e;
                e = sb_q.pop_front();
                chk("wr_data", {16'h0, wr_data}, {16'h0, e});
                chk("wr_parity", {31'h0, wr_parity}, {31'h0, exp_par(e)});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic arm(input logic sf, input logic st);
        start_f = sf;
        start_t = st;
        step();
        start_f = 1'b0;
        start_t = 1'b0;
        step();
    endtask

    logic [1:0] en_exp [8];
    int fn, tn;

    initial begin
        rst = 1'b1;
        {start_f, start_t, stop, f_valid, t_valid} = '0;
        f_data = '0; t_data = '0;
        buffer_full = 1'b0; buffer_empty = 1'b1; data_2_valid = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_f_en",     {31'h0, f_en},     0);
        chk("rst_t_en",     {31'h0, t_en},     0);
        chk("rst_wr_en",    {31'h0, wr_en},    0);
        chk("rst_overflow", {31'h0, overflow}, 0);
        chk("rst_parity",   {31'h0, wr_parity}, 0);
        chk("rst_wr_data",  {16'h0, wr_data},  0);
        chk("rst_word_cnt", {16'h0, word_cnt}, 0);
        chk("rst_modulo",   {30'h0, modulo},   0);
        rst = 1'b0;
        step();

        // Fibonacci only: five words 0,1,1,2,3
        arm(1'b1, 1'b0);
        chk("fib_f_en", {31'h0, f_en}, 1);
        chk("fib_modulo", {30'h0, modulo}, 2'b10);
        begin
            logic [DW-1:0] fib [5];
            fib[0] = 0; fib[1] = 1; fib[2] = 1; fib[3] = 2; fib[4] = 3;
            for (int i = 0; i < 5; i++) begin
                f_valid = 1'b1;
                f_data  = fib[i];
                sb_q.push_back(fib[i]);
                step();
                chk("fib_lat_wr_en", {31'h0, wr_en}, 1);
                chk("fib_t_en", {31'h0, t_en}, 0);
            end
        end
        f_valid = 1'b0;
        step();
        step();
        chk("fib_word_cnt", {16'h0, word_cnt}, 5);
        chk("fib_modulo_end", {30'h0, modulo}, 2'b10);
        chk("fib_sb_empty", sb_q.size(), 0);
        do_reset();

        // Both armed, SLICE=2: F,F,T,T,F,F with one dead cycle per switch
        en_exp[0] = 2'b10; en_exp[1] = 2'b10; en_exp[2] = 2'b00; en_exp[3] = 2'b01;
        en_exp[4] = 2'b01; en_exp[5] = 2'b00; en_exp[6] = 2'b10; en_exp[7] = 2'b10;
        sb_q.push_back(16'hF000); sb_q.push_back(16'hF001);
        sb_q.push_back(16'hA000); sb_q.push_back(16'hA001);
        sb_q.push_back(16'hF002); sb_q.push_back(16'hF003);
        fn = 0; tn = 0;
        arm(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("rr_enables", {30'h0, f_en, t_en}, {30'h0, en_exp[i]});
            if (i == 3) chk("rr_modulo_t", {30'h0, modulo}, 2'b01);
            f_valid = f_en;
            t_valid = t_en;
            f_data  = 16'hF000 + 16'(fn);
            t_data  = 16'hA000 + 16'(tn);
            if (f_en) fn++;
            if (t_en) tn++;
            step();
        end
        f_valid = 1'b0;
        t_valid = 1'b0;
        step();
        step();
        chk("rr_word_cnt", {16'h0, word_cnt}, 6);
        chk("rr_sb_empty", sb_q.size(), 0);
        do_reset();

        // Stall: word in flight as FIFO goes full
        arm(1'b1, 1'b0);
        f_valid = 1'b1; f_data = 16'h0100; buffer_full = 1'b1;
        sb_q.push_back(16'h0100);
        step();
        f_valid = 1'b0;
        chk("stall_f_en", {31'h0, f_en}, 0);
        chk("stall_wr_en0", {31'h0, wr_en}, 0);
        step();
        chk("stall_wr_en1", {31'h0, wr_en}, 0);
        buffer_full = 1'b0;
        step();
        chk("stall_flush_wr_en", {31'h0, wr_en}, 1);
        chk("stall_flush_f_en", {31'h0, f_en}, 0);
        step();
        chk("stall_resume_f_en", {31'h0, f_en}, 1);

        // Overflow: second word while hold occupied and FIFO full
        f_valid = 1'b1; f_data = 16'h0200; buffer_full = 1'b1;
        sb_q.push_back(16'h0200);
        step();
        f_data = 16'h0201;
        step();
        f_valid = 1'b0;
        chk("ovf_set", {31'h0, overflow}, 1);
        buffer_full = 1'b0;
        step();
        step();
        step();
        chk("ovf_sticky", {31'h0, overflow}, 1);
        chk("ovf_word_cnt", {16'h0, word_cnt}, 2);
        chk("ovf_sb_empty", sb_q.size(), 0);
        do_reset();
        chk("ovf_cleared", {31'h0, overflow}, 0);

        // Stop / drain
        arm(1'b1, 1'b0);
        f_valid = 1'b1; f_data = 16'h0300; stop = 1'b1;
        buffer_empty = 1'b0; data_2_valid = 1'b1;
        sb_q.push_back(16'h0300);
        step();
        f_valid = 1'b0; stop = 1'b0;
        chk("drain_f_en", {31'h0, f_en}, 0);
        chk("drain_t_en", {31'h0, t_en}, 0);
        start_t = 1'b1;
        step();
        start_t = 1'b0;
        step();
        chk("drain_hold_modulo", {30'h0, modulo}, 2'b10);
        buffer_empty = 1'b1;
        step();
        step();
        chk("drain_d2v_modulo", {30'h0, modulo}, 2'b10);
        data_2_valid = 1'b0;
        step();
        chk("drain_idle_modulo", {30'h0, modulo}, 2'b00);
        step();
        step();
        chk("idle_f_en", {31'h0, f_en}, 0);
        chk("idle_t_en", {31'h0, t_en}, 0);
        chk("idle_modulo", {30'h0, modulo}, 2'b00);
        do_reset();

        // Parity words
        arm(1'b1, 1'b0);
        f_valid = 1'b1; f_data = 16'h0007;
        sb_q.push_back(16'h0007);
        step();
        chk("par_0007", {31'h0, wr_parity}, {31'h0, exp_par(16'h0007)});
        f_data = 16'h0003;
        sb_q.push_back(16'h0003);
        step();
        chk("par_0003", {31'h0, wr_parity}, 0);
        f_valid = 1'b0;
        step();
        step();
        chk("final_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/src_scheduler.md
# src_scheduler

Sequencer and time-slice arbiter that shares the single clock-domain-crossing FIFO write port between the fibonacci and timer producers. It arms each producer from start pulses and drives the producer enables. It absorbs FIFO backpressure with a one-word hold register and runs the stop/drain sequence. It sits between the edge detectors, the two producers and the FIFO wrapper, replacing the top-level enable FSM.

## Interface
Parameters:
- DATA_W, 16, producer/FIFO word width
- SLICE, 8, maximum words accepted from one producer per grant when both are armed (≥1)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start_f  in  1  single-cycle pulse, arms fibonacci source
- start_t  in  1  single-cycle pulse, arms timer source
- stop  in  1  single-cycle pulse, begins drain
- f_valid / t_valid  in  1  producer word strobes
- f_data / t_data  in  DATA_W  producer words
- buffer_full  in  1  FIFO full
- buffer_empty  in  1  FIFO empty
- data_2_valid  in  1  FIFO read side still presenting a word
- f_en / t_en  out  1  producer enables
- wr_en  out  1  FIFO write strobe, registered
- wr_data  out  DATA_W  FIFO write word, registered
- modulo  out  2  active source: 2'b10 fib, 2'b01 timer, 2'b00 idle
- word_cnt  out  16  total FIFO writes, wraps 0xFFFF→0x0000
- overflow  out  1  sticky: word lost because hold register was occupied
- wr_parity  out  1  see Configuration

## Operation
- Arm flags arm_f/arm_t set on start_f/start_t in any state except DRAIN. They are cleared only on the DRAIN→IDLE transition or by reset.
- Grant register g (F/T) and last-grant register are used. Last-grant resets to T, so F wins the first tie.
- States:
  - IDLE: when arm_f|arm_t, pick g by round-robin (the source other than last-grant if it is armed, else the armed one), then go to GRANT.
  - GRANT: enable of g = 1.
    - stop → DRAIN (highest priority).
    - buffer_full → STALL.
    - Accept with slice_cnt==SLICE-1 and the other source armed → SWITCH.
  - STALL: enables 0. stop → DRAIN. Return to GRANT when !buffer_full and the hold register is empty.
  - SWITCH: exactly one cycle with enables 0, to catch in-flight words. Flip g, update last-grant, clear slice_cnt, then go to GRANT (or STALL if buffer_full).
  - DRAIN: enables 0. Go to IDLE when hold empty & buffer_empty & ~data_2_valid.
- f_en/t_en are decoded from state and g only; there is no combinational path from any input.
- Accept: valid of source g, in any non-IDLE state. Valid of the non-granted source is ignored. Each accept in GRANT increments slice_cnt.
- Write path, evaluated each cycle in this priority:
  - Hold occupied and !buffer_full → write the hold word, then free the hold register.
  - Accepted word, hold empty, !buffer_full → write it directly.
  - Accepted word otherwise → store it in hold. If hold is already occupied (and not freed this cycle), drop the word and set overflow.
- A direct write and a hold flush can never both occur in one cycle. If an accept coincides with a flush, the accepted word goes to hold.
- modulo follows g in non-IDLE states and is 2'b00 in IDLE.

## Timing
- Reset values:
  - state IDLE, g = F, last-grant T
  - f_en = t_en = wr_en = overflow = wr_parity = 0
  - wr_data = 0, word_cnt = 0, modulo = 2'b00
  - arm flags and hold register cleared
- Accept→wr_en latency: 1 cycle when not backpressured.
- Enable timing:
  - Start pulse to arm flag: 1 cycle.
  - Arm flag to IDLE→GRANT: 1 cycle.
  - Enable high in the first GRANT cycle.
- buffer_full going high drops the enable the next cycle. One in-flight word may still arrive and is held.
- stop and buffer_full in the same cycle: stop wins. start during DRAIN is ignored.
- Reset mid-operation: all state is discarded immediately (asynchronous) and the held word is lost.

## Configuration
- SCHED_PARITY_EN defined: wr_parity is registered alongside wr_data and equals the XOR of all wr_data bits, valid whenever wr_en=1.
- Not defined: wr_parity is tied to 0 and no parity logic is built.

## Test plan
- Fib only: start_f, 5 valid words 0,1,1,2,3 with FIFO never full → wr_en 5×, wr_data in order, word_cnt=5, modulo=2'b10, t_en stays 0.
- Both armed, SLICE=2, both producers streaming → write order F,F,T,T,F,F; exactly one SWITCH cycle with f_en=t_en=0 between slices.
- buffer_full asserted while an fib word is in flight → word held; wr_en=0 while full; held word written 1 cycle after full drops; then GRANT resumes.
- Two words arrive while full with hold occupied → second dropped, overflow=1 and stays 1 until rst.
- stop during GRANT with FIFO non-empty → enables 0 next cycle; IDLE only after buffer_empty=1 and data_2_valid=0; arm flags cleared; start_t during DRAIN ignored.
- With SCHED_PARITY_EN, write 0x0007 → wr_parity=1; write 0x0003 → 0. Without the macro → wr_parity always 0.
